// File: rtl/mul_int.sv
// Sequential 32x32 integer multiplier: radix-2 shift-add over operand magnitudes,
// one sign-correction cycle, start/done handshake. Product is returned as hi/lo.
module mul_int #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sgn,
    input  logic [W-1:0] mcand,
    input  logic [W-1:0] mplier,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         ovf
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W:0]     sum;
    logic [2*W-1:0] res;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum     = '0;
        res     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Magnitudes as unsigned W-bit values; the most negative value maps to itself.
                    sgn_d   = sgn;
                    a_d     = (sgn && mcand[W-1])  ? -mcand  : mcand;
                    b_d     = (sgn && mplier[W-1]) ? -mplier : mplier;
                    neg_d   = sgn & (mcand[W-1] ^ mplier[W-1]);
                    p_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum   = {1'b0, p_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : '0);
                p_d   = {sum, p_q[W-1:1]};
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res     = neg_q ? -p_q : p_q;
                hi_d    = res[2*W-1:W];
                lo_d    = res[W-1:0];
                ovf_d   = sgn_q ? (res[2*W-1:W] != {W{res[W-1]}})
                                : (res[2*W-1:W] != '0);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/mul_int.md
Name: mul_int

Overview:
Sequential 32x32 integer multiplier producing a 64-bit product in hi/lo halves. It is the companion of the team's 64/32 integer divider: its outputs (hi, lo) have the same shape as the divider's dividend input. It shares the divider's clock and sits beside it in the ALU/HI-LO path. It uses a radix-2 shift-add over operand magnitudes, with a final sign-correction cycle, and a start/done handshake.

Parameters:
- W, 32, operand width; product is 2*W. Only 32 is verified.

Ports:
- clk     in   1   system clock, rising edge
- rst_n   in   1   reset; synchronous, active-low
- start   in   1   request; sampled only in IDLE
- sgn     in   1   1 = two's-complement operands, 0 = unsigned; sampled with start
- mcand   in   32  multiplicand; sampled with start
- mplier  in   32  multiplier; sampled with start
- busy    out  1   operation in progress
- done    out  1   one-cycle pulse; hi/lo/ovf valid from this cycle
- hi      out  32  product[63:32]
- lo      out  32  product[31:0]
- ovf     out  1   product not representable in 32 bits

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state: the FSM goes to IDLE. busy, done, hi, lo, ovf and the iteration counter are all 0.
- Reset mid-operation: the operation is abandoned and the reset values apply on the next edge. No done pulse is produced.
- FSM states: IDLE, RUN, FIX.
- IDLE, when start=1 at edge N:
  - Latch sgn.
  - Latch magnitudes A=|mcand| and B=|mplier| as 32-bit unsigned values. With sgn=0 the operands are taken as-is. With sgn=1, 0x80000000 has magnitude 0x80000000.
  - Latch neg = sgn & (mcand[31]^mplier[31]).
  - Clear the 64-bit accumulator P to 0 and set cnt=0.
  - Set busy=1 and go to RUN.
- RUN, one iteration per edge, edges N+1..N+32:
  - If B[0]=1, add A to P[63:32] in a 33-bit sum, keeping the carry.
  - Shift {carry,P} right 1 and shift B right 1.
  - cnt++.
  - At cnt==31, go to FIX.
- FIX, edge N+33:
  - Product R = neg ? -P : P (64-bit two's complement).
  - Register hi=R[63:32] and lo=R[31:0].
  - Overflow: ovf = sgn ? (hi != {32{lo[31]}}) : (hi != 0).
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency: start sampled at edge N; done is high in the cycle following edge N+33. The throughput is one result per 34 cycles. start may be reasserted in the done cycle and is accepted at that edge.
- Start handling: start while busy is ignored and does not corrupt the operation. Operand inputs are don't-care after edge N.
- Output hold: hi/lo/ovf hold their last result until the next FIX or reset.
- Zero operand: product 0, ovf=0. There is no error output; multiply has no invalid input.
- Signed 0x80000000 x 0x80000000 = +2^62: hi=0x40000000, lo=0, ovf=1.

Test Plan:
- Reset, then release rst_n with start=0 -> busy=done=ovf=0, hi=lo=0; the block stays idle indefinitely.
- sgn=1, mcand=-7 (0xFFFFFFF9), mplier=3 -> done exactly 33 cycles after the accepting edge: hi=0xFFFFFFFF, lo=0xFFFFFFEB, ovf=0. Same operands with sgn=0 -> hi=0x00000002, lo=0xFFFFFFEB, ovf=1.
- sgn=0, 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, ovf=1.
- sgn=1, 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0, ovf=1.
- sgn=1, 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000, ovf=0.
- Operand 0 in either position -> hi=lo=0, ovf=0.
- Pulse start again at RUN cycle 10 with different operands -> ignored; the first result is correct.
- Issue a new start in the done cycle -> the second result is correct 34 cycles later.
- Assert rst_n=0 at RUN cycle 15 -> next cycle busy=0, outputs 0, no done pulse.
- Random sweep: 10k random operand pairs in both sgn modes, checked against a 64-bit reference model.
